// File: rtl/regfile_banked.sv
// Dual-bank register file: two combinational read ports, one byte-enabled write port, R0 reads zero.
// Define REGFILE_BYPASS_EN to forward the in-flight write to a matching read port in the same cycle.
module regfile_banked #(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    localparam int NB   = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [NB-1:0]    BE,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    input  logic             BANK_SW,
    output logic             BANK
);
    localparam int NREG = 2 ** AW;

    logic [WIDTH-1:0] regs_q [2][NREG];
    logic             bank_q;
    logic             bank_d;
    logic             wr_en;
    logic [WIDTH-1:0] wr_merged;

    assign wr_en  = WE && (WA != '0);
    assign bank_d = bank_q ^ BANK_SW;
    assign BANK   = bank_q;

    // Lanes without an enable keep the stored value of the pre-edge active bank.
    always_comb begin
        wr_merged = regs_q[bank_q][WA];
        for (int i = 0; i < NB; i++) begin
            if (BE[i]) begin
                wr_merged[8*i +: 8] = WD[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            bank_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < NREG; r++) begin
                    regs_q[b][r] <= '0;
                end
            end
        end else begin
            bank_q <= bank_d;
            if (wr_en) begin
                regs_q[bank_q][WA] <= wr_merged;
            end
        end
    end

    always_comb begin
        RD1 = regs_q[bank_q][RA1];
        RD2 = regs_q[bank_q][RA2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && !CLR && (WA == RA1)) begin
            RD1 = wr_merged;
        end
        if (wr_en && !CLR && (WA == RA2)) begin
            RD2 = wr_merged;
        end
`endif
        if (RA1 == '0) begin
            RD1 = '0;
        end
        if (RA2 == '0) begin
            RD2 = '0;
        end
    end

endmodule
